// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_pkg
//  Brief    : Shared widths, encodings and bundle sizing for the MIPS core.
//  Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int DEF_PC_W    = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_CMD_W   = 4;
    localparam int DEF_RADDR_W = 5;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEZ  = 2'b01,
        BR_BNE  = 2'b10,
        BR_JMP  = 2'b11
    } br_type_e;

    typedef enum logic [3:0] {
        EX_NOP = 4'b0000,
        EX_ADD = 4'b0001,
        EX_SUB = 4'b0010,
        EX_AND = 4'b0011,
        EX_OR  = 4'b0100,
        EX_XOR = 4'b0101,
        EX_SLT = 4'b0110,
        EX_SLL = 4'b0111,
        EX_SRL = 4'b1000
    } ex_cmd_e;

    // pc + wb_en/mem_wr/mem_rd + br_type + ex_cmd + val1/val2/reg2 + dst/src1/src2
    function automatic int bundle_width(input int pc_w, input int data_w,
                                        input int cmd_w, input int raddr_w);
        return pc_w + 3 + 2 + cmd_w + 3 * data_w + 3 * raddr_w;
    endfunction

    localparam int BUNDLE_W = bundle_width(DEF_PC_W, DEF_DATA_W, DEF_CMD_W, DEF_RADDR_W);

endpackage
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_slot
//  Brief    : One pipeline slot: valid bit plus packed payload, zeroed when empty.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Clearing always zeroes the payload so an empty slot carries no control bits.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/id_ex_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_pipe_stage
//  Brief    : ID->EX register stage with valid/ready, optional skid slot, flush.
//             Define ID_EX_SKID_EN for the two-slot, registered-in_ready variant.
//  Revision : 1.0 - initial release
// ============================================================================
module id_ex_pipe_stage
    import mips_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CMD_W   = DEF_CMD_W,
    parameter int RADDR_W = DEF_RADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic               in_wb_en,
    input  logic               in_mem_wr,
    input  logic               in_mem_rd,
    input  logic [1:0]         in_br_type,
    input  logic [CMD_W-1:0]   in_ex_cmd,
    input  logic [DATA_W-1:0]  in_val1,
    input  logic [DATA_W-1:0]  in_val2,
    input  logic [DATA_W-1:0]  in_reg2,
    input  logic [RADDR_W-1:0] in_dst,
    input  logic [RADDR_W-1:0] in_src1,
    input  logic [RADDR_W-1:0] in_src2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic               out_wb_en,
    output logic               out_mem_wr,
    output logic               out_mem_rd,
    output logic [1:0]         out_br_type,
    output logic [CMD_W-1:0]   out_ex_cmd,
    output logic [DATA_W-1:0]  out_val1,
    output logic [DATA_W-1:0]  out_val2,
    output logic [DATA_W-1:0]  out_reg2,
    output logic [RADDR_W-1:0] out_dst,
    output logic [RADDR_W-1:0] out_src1,
    output logic [RADDR_W-1:0] out_src2,
    output logic [15:0]        stall_cnt
);

    localparam int          c_BUNDLE_W  = bundle_width(PC_W, DATA_W, CMD_W, RADDR_W);
    localparam logic [15:0] c_STALL_MAX = 16'hFFFF;

    logic                  w_in_fire;
    logic                  w_out_fire;
    logic [c_BUNDLE_W-1:0] w_in_bundle;
    logic                  w_m_valid;
    logic                  w_m_load;
    logic                  w_m_clear;
    logic [c_BUNDLE_W-1:0] w_m_load_data;
    logic [c_BUNDLE_W-1:0] w_m_data;
    logic [15:0]           r_stall_cnt;

    assign w_in_bundle = {in_pc, in_wb_en, in_mem_wr, in_mem_rd, in_br_type, in_ex_cmd,
                          in_val1, in_val2, in_reg2, in_dst, in_src1, in_src2};

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = w_m_valid && out_ready;

`ifdef ID_EX_SKID_EN
    logic                  w_s_valid;
    logic                  w_s_load;
    logic                  w_s_clear;
    logic [c_BUNDLE_W-1:0] w_s_data;

    // Ready depends only on the skid slot state, never on out_ready.
    assign in_ready = !w_s_valid && !rst;

    // When S is occupied in_ready is low, so a refill of M can only come from S.
    assign w_m_load      = (w_out_fire && w_s_valid) ||
                           (w_in_fire && (!w_m_valid || w_out_fire));
    assign w_m_load_data = w_s_valid ? w_s_data : w_in_bundle;
    assign w_m_clear     = flush || (w_out_fire && !w_m_load);

    assign w_s_load  = w_in_fire && w_m_valid && !w_out_fire;
    assign w_s_clear = flush || (w_out_fire && w_s_valid);

    pipe_slot #(
        .W (c_BUNDLE_W)
    ) u_slot_s (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_s_load),
        .i_clear (w_s_clear),
        .i_data  (w_in_bundle),
        .o_valid (w_s_valid),
        .o_data  (w_s_data)
    );
`else
    assign in_ready = (!w_m_valid || out_ready) && !rst;

    assign w_m_load      = w_in_fire;
    assign w_m_load_data = w_in_bundle;
    assign w_m_clear     = flush || (w_out_fire && !w_in_fire);
`endif

    pipe_slot #(
        .W (c_BUNDLE_W)
    ) u_slot_m (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_m_load),
        .i_clear (w_m_clear),
        .i_data  (w_m_load_data),
        .o_valid (w_m_valid),
        .o_data  (w_m_data)
    );

    assign out_valid = w_m_valid;
    assign {out_pc, out_wb_en, out_mem_wr, out_mem_rd, out_br_type, out_ex_cmd,
            out_val1, out_val2, out_reg2, out_dst, out_src1, out_src2} = w_m_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_m_valid && !out_ready && (r_stall_cnt != c_STALL_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_pipe_stage
//  Brief    : Directed, table-driven bench for id_ex_pipe_stage (both builds).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_pipe_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic        in_wb_en, in_mem_wr, in_mem_rd;
    logic [1:0]  in_br_type;
    logic [3:0]  in_ex_cmd;
    logic [31:0] in_val1, in_val2, in_reg2;
    logic [4:0]  in_dst, in_src1, in_src2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic        out_wb_en, out_mem_wr, out_mem_rd;
    logic [1:0]  out_br_type;
    logic [3:0]  out_ex_cmd;
    logic [31:0] out_val1, out_val2, out_reg2;
    logic [4:0]  out_dst, out_src1, out_src2;
    logic [15:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    id_ex_pipe_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_wb_en(in_wb_en), .in_mem_wr(in_mem_wr), .in_mem_rd(in_mem_rd),
        .in_br_type(in_br_type), .in_ex_cmd(in_ex_cmd),
        .in_val1(in_val1), .in_val2(in_val2), .in_reg2(in_reg2),
        .in_dst(in_dst), .in_src1(in_src1), .in_src2(in_src2),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_wb_en(out_wb_en), .out_mem_wr(out_mem_wr), .out_mem_rd(out_mem_rd),
        .out_br_type(out_br_type), .out_ex_cmd(out_ex_cmd),
        .out_val1(out_val1), .out_val2(out_val2), .out_reg2(out_reg2),
        .out_dst(out_dst), .out_src1(out_src1), .out_src2(out_src2),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every payload field is a distinct function of the PC so swaps and drops show up.
    function automatic logic [151:0] exp_bundle(input logic [31:0] pc);
        logic [4:0] r;
        r = pc[6:2];
        return {pc, ~pc[2], pc[2], pc[3], pc[3:2] ^ 2'b01, pc[5:2] ^ 4'h9,
                pc ^ 32'hA5A5_0000, pc + 32'h100, ~pc, r, r + 5'd1, r + 5'd2};
    endfunction

    function automatic logic [151:0] act_bundle();
        return {out_pc, out_wb_en, out_mem_wr, out_mem_rd, out_br_type, out_ex_cmd,
                out_val1, out_val2, out_reg2, out_dst, out_src1, out_src2};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic exp_v, input logic [31:0] pc);
        if (exp_v)
            chk(name, {1'b1 & out_valid, act_bundle()}, {1'b1, exp_bundle(pc)});
        else
            chk(name, {out_valid, out_wb_en, out_mem_wr, out_mem_rd, out_br_type, out_ex_cmd}, '0);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
        logic [151:0] b;
        b = exp_bundle(pc);
        in_valid  = v;
        out_ready = ordy;
        flush     = fl;
        {in_pc, in_wb_en, in_mem_wr, in_mem_rd, in_br_type, in_ex_cmd,
         in_val1, in_val2, in_reg2, in_dst, in_src1, in_src2} = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic        ordy;
        logic        fl;
        logic        exp_rdy;
        logic        exp_ov;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[7];

    logic [31:0] tog_pcs[4];
    logic        exp_mv;
    logic [31:0] exp_mpc;
    int          idx;
    int          cons;
    logic        e_rdy;
    logic        e_fire;

    initial begin
        vecs[0] = '{1'b1, 32'h00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00};
        vecs[1] = '{1'b1, 32'h04, 1'b1, 1'b0, 1'b1, 1'b1, 32'h04};
        vecs[2] = '{1'b1, 32'h08, 1'b1, 1'b0, 1'b1, 1'b1, 32'h08};
        vecs[3] = '{1'b0, 32'h0C, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00};
        vecs[4] = '{1'b1, 32'h20, 1'b1, 1'b0, 1'b1, 1'b1, 32'h20};
        vecs[5] = '{1'b1, 32'h24, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00};
        vecs[6] = '{1'b0, 32'h28, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00};

        // Reset held two cycles with an instruction offered.
        rst = 1'b1;
        drive(1'b1, 32'h1234_5678, 1'b1, 1'b0);
        tick();
        chk("reset_c1", {out_valid, act_bundle(), in_ready}, '0);
        tick();
        chk("reset_c2", {out_valid, act_bundle(), in_ready}, '0);
        rst = 1'b0;
        #1;
        chk("reset_rel_rdy", {15'd0, in_ready, stall_cnt}, {15'd0, 1'b1, 16'h0000});

        // Streaming, drain, and flush dropping an accepted input.
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].iv, vecs[i].pc, vecs[i].ordy, vecs[i].fl);
            #1;
            chk($sformatf("vec%0d_rdy", i), in_ready, vecs[i].exp_rdy);
            tick();
            check_out($sformatf("vec%0d_out", i), vecs[i].exp_ov, vecs[i].exp_pc);
        end

        // Flush with the stage backed up and a new instruction offered.
        drive(1'b1, 32'h30, 1'b1, 1'b0);
        tick();
        check_out("fl_fill_m", 1'b1, 32'h30);
        drive(1'b1, 32'h34, 1'b0, 1'b0);
        tick();
        check_out("fl_hold_m", 1'b1, 32'h30);
        drive(1'b1, 32'h38, 1'b0, 1'b1);
        #1;
        chk("fl_pre_rdy", in_ready, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("fl_after", {out_valid, out_wb_en, out_mem_wr, out_pc, in_ready},
            {1'b0, 1'b0, 1'b0, 32'h0, 1'b1});
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        tick();
        chk("fl_no_ghost", out_valid, 1'b0);

`ifdef ID_EX_SKID_EN
        // Back-pressure: 0x14 parks in S, 0x18 waits, then ordered release.
        drive(1'b1, 32'h10, 1'b1, 1'b0);
        tick();
        check_out("bp_m10", 1'b1, 32'h10);
        drive(1'b1, 32'h14, 1'b0, 1'b0);
        #1;
        chk("bp_rdy_before_s", in_ready, 1'b1);
        tick();
        check_out("bp_hold10_a", 1'b1, 32'h10);
        chk("bp_rdy_s_full", in_ready, 1'b0);
        drive(1'b1, 32'h18, 1'b0, 1'b0);
        tick();
        check_out("bp_hold10_b", 1'b1, 32'h10);
        chk("bp_rdy_still0", in_ready, 1'b0);
        drive(1'b1, 32'h18, 1'b1, 1'b0);
        tick();
        check_out("bp_out14", 1'b1, 32'h14);
        chk("bp_rdy_back", in_ready, 1'b1);
        tick();
        check_out("bp_out18", 1'b1, 32'h18);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        check_out("bp_drained", 1'b0, 32'h0);
`else
        // out_ready toggling: in_ready follows !M.valid || out_ready combinationally.
        tog_pcs[0] = 32'h40;
        tog_pcs[1] = 32'h44;
        tog_pcs[2] = 32'h48;
        tog_pcs[3] = 32'h4C;
        exp_mv  = 1'b0;
        exp_mpc = 32'h0;
        idx     = 0;
        cons    = 0;
        for (int c = 0; c < 12; c++) begin
            drive(idx < 4, (idx < 4) ? tog_pcs[idx] : 32'h0, (c % 2) == 0, 1'b0);
            #1;
            e_rdy  = !exp_mv || out_ready;
            e_fire = exp_mv && out_ready;
            chk($sformatf("tog%0d_rdy", c), in_ready, e_rdy);
            if (e_fire) begin
                chk($sformatf("tog%0d_consumed", c), out_pc, tog_pcs[cons]);
                cons++;
            end
            if (in_valid && e_rdy) begin
                exp_mv  = 1'b1;
                exp_mpc = tog_pcs[idx];
                idx++;
            end else if (e_fire) begin
                exp_mv = 1'b0;
            end
            tick();
            check_out($sformatf("tog%0d_out", c), exp_mv, exp_mpc);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
`endif

        // Stall counter from a fresh reset, through saturation; flush leaves it alone.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b1, 32'h50, 1'b1, 1'b0);
        tick();
        chk("st_zero", stall_cnt, 16'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (5) tick();
        chk("st_five", stall_cnt, 16'd5);
        repeat (65529) tick();
        chk("st_fffe", stall_cnt, 16'hFFFE);
        repeat (3) tick();
        chk("st_sat", stall_cnt, 16'hFFFF);
        check_out("st_still_held", 1'b1, 32'h50);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("st_flush_keep", {out_valid, stall_cnt}, {1'b0, 16'hFFFF});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
